mii_tx: RTL and testbench

MAC-to-PHY transmit serializer on the PHY side of the MAC's transmit byte stream. It accepts frame bytes (preamble, SFD, payload and FCS already built by the MAC) over a valid/ready handshake. It drives them onto the 4-bit MII transmit bus, low nibble first, one nibble per clock. It also enforces the inter-packet gap and corrupts the frame with TX_ER if the byte stream underruns mid-frame.

---
 rtl/eth_pkg.sv | 17 +
 rtl/mii_tx.sv | 129 ++++++++++++
 tb/tb_mii_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/MII definitions: transmit FSM states,
// default inter-packet gap and MII nibble width.
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      ERR,
      DRAIN,
      IPG
   } state_t;

   localparam int ETH_IPG_NIBBLES = 24;
   localparam int MII_W = 4;

endpackage

// File: rtl/mii_tx.sv
// Byte stream to 4-bit MII transmit serializer with
// inter-packet gap enforcement and underrun signalling.
module mii_tx
   import eth_pkg::*;
#(
   parameter int IPG_NIBBLES = ETH_IPG_NIBBLES
) (
   input  logic             in_txc,
   input  logic             in_rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_ready,
   output logic             out_mii_txen,
   output logic [MII_W-1:0] out_mii_txd,
   output logic             out_mii_txer,
   output logic             out_busy,
   output logic             out_underrun
);

   localparam int CW = $clog2(IPG_NIBBLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(IPG_NIBBLES - 2);

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             txen_d, txer_d, und_d;
   logic [MII_W-1:0] txd_d;
   logic             accept;

   assign out_busy = (state_q != IDLE);
   assign accept   = in_valid && out_ready;

   always_comb begin
      out_ready = 1'b0;
      if (in_rst_n) begin
         unique case (state_q)
            IDLE, DRAIN: out_ready = 1'b1;
            HI:          out_ready = !last_q;
            default:     out_ready = 1'b0;
         endcase
      end
   end

   // Outputs are computed from the next state so they register
   // in the same edge that enters the state.
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      txen_d  = 1'b0;
      txd_d   = '0;
      txer_d  = 1'b0;
      und_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LO;
               byte_d  = in_data;
               last_d  = in_last;
               txen_d  = 1'b1;
               txd_d   = in_data[3:0];
            end
         end
         LO: begin
            state_d = HI;
            txen_d  = 1'b1;
            txd_d   = byte_q[7:4];
         end
         HI: begin
            if (accept) begin
               state_d = LO;
               byte_d  = in_data;
               last_d  = in_last;
               txen_d  = 1'b1;
               txd_d   = in_data[3:0];
            end else if (last_q) begin
               state_d = IPG;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ERR;
               txen_d  = 1'b1;
               txer_d  = 1'b1;
               und_d   = 1'b1;
            end
         end
         ERR: state_d = DRAIN;
         DRAIN: begin
            if (accept && in_last) begin
               state_d = IPG;
               cnt_d   = CNT_LOAD;
            end
         end
         IPG: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_txc) begin
      if (!in_rst_n) begin
         state_q      <= IDLE;
         byte_q       <= '0;
         last_q       <= 1'b0;
         cnt_q        <= '0;
         out_mii_txen <= 1'b0;
         out_mii_txd  <= '0;
         out_mii_txer <= 1'b0;
         out_underrun <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         out_mii_txen <= txen_d;
         out_mii_txd  <= txd_d;
         out_mii_txer <= txer_d;
         out_underrun <= und_d;
      end
   end

endmodule

// File: tb/tb_mii_tx.sv
// Bench for mii_tx: vector table, directed corner cases,
// and random frames checked by a frame-level monitor.
module tb_mii_tx;

   localparam int IPG  = 24;
   localparam int IPG4 = 4;
   localparam int NF   = 25;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       valid, last;
   logic [7:0] data;
   logic       rdy, en, er, und, busy;
   logic [3:0] txd;

   logic       v4, l4;
   logic [7:0] d4;
   logic       rdy4, en4, er4, und4, busy4;
   logic [3:0] txd4;

   mii_tx dut (
      .in_txc(clk), .in_rst_n(rst_n),
      .in_valid(valid), .in_data(data), .in_last(last),
      .out_ready(rdy), .out_mii_txen(en),
      .out_mii_txd(txd), .out_mii_txer(er),
      .out_busy(busy), .out_underrun(und)
   );

   mii_tx #(.IPG_NIBBLES(IPG4)) dut4 (
      .in_txc(clk), .in_rst_n(rst_n),
      .in_valid(v4), .in_data(d4), .in_last(l4),
      .out_ready(rdy4), .out_mii_txen(en4),
      .out_mii_txd(txd4), .out_mii_txer(er4),
      .out_busy(busy4), .out_underrun(und4)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic       r, v;
      logic [7:0] d;
      logic       l;
      logic       en;
      logic [3:0] txd;
      logic       er, und, rdy, busy;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, v, input logic [7:0] d,
                      input logic l, en, input logic [3:0] t,
                      input logic e, u, y, b);
      vec_t x;
      x = '{r, v, d, l, en, t, e, u, y, b};
      vt.push_back(x);
   endtask

   task automatic apply_rows(input int lo, input int hi);
      logic [8:0] g, x;
      for (int i = lo; i <= hi; i++) begin
         rst_n = vt[i].r;
         valid = vt[i].v;
         data  = vt[i].d;
         last  = vt[i].l;
         @(negedge clk);
         g = {en, txd, er, und, rdy, busy};
         x = {vt[i].en, vt[i].txd, vt[i].er,
              vt[i].und, vt[i].rdy, vt[i].busy};
         chk($sformatf("vec%0d", i), int'(g), int'(x));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 0;
      valid = 1'b0;
      last  = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rdy && !busy) ok = 1;
         @(posedge clk);
         #1;
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      bit acc;
      acc = 0;
      valid = 1'b1;
      data  = d;
      last  = l;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = rdy;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic send4(input logic [7:0] d, input logic l);
      bit acc;
      acc = 0;
      v4 = 1'b1;
      d4 = d;
      l4 = l;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = rdy4;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send4_timeout", 0, 1);
   endtask

   // frame-level reference: expected nibbles, lengths, gaps
   bit         mon_en = 0;
   logic [3:0] exp_nib[$];
   int         exp_len[$];
   int         exp_gap[$];
   logic [3:0] cur[$];
   bit         in_fr = 0;
   bit         bad_seen;
   int         gap_n = 0, rdy_n = 0;
   int         g_k, g_e, f_len;
   bit         f_ok;
   logic [3:0] f_n;

   always @(negedge clk) begin
      if (mon_en) begin
         if (en) begin
            if (!in_fr) begin
               in_fr = 1;
               cur.delete();
               bad_seen = 0;
               if (exp_gap.size() == 0) begin
                  chk("rnd_unexpected_frame", 1, 0);
               end else begin
                  g_k = exp_gap.pop_front();
                  if (g_k >= 0) begin
                     g_e = (g_k - 1 > IPG) ? g_k - 1 : IPG;
                     chk("rnd_gap", gap_n, g_e);
                     chk("rnd_ready_in_gap", rdy_n, g_e - (IPG - 1));
                  end
               end
            end
            cur.push_back(txd);
            if (er || und) bad_seen = 1;
         end else begin
            if (in_fr) begin
               in_fr = 0;
               chk("rnd_txer", int'(bad_seen), 0);
               if (exp_len.size() == 0) begin
                  chk("rnd_extra_frame", 1, 0);
               end else begin
                  f_len = exp_len.pop_front();
                  f_ok = (cur.size() == f_len);
                  for (int i = 0; i < f_len; i++) begin
                     f_n = exp_nib.pop_front();
                     if (i < cur.size() && cur[i] != f_n) f_ok = 0;
                  end
                  chk("rnd_frame", int'(f_ok), 1);
               end
               gap_n = 0;
               rdy_n = 0;
            end
            gap_n++;
            rdy_n += int'(rdy);
         end
      end
   end

   logic       rec_en[40];
   logic       rec_rdy[40];
   logic [3:0] rec_txd[40];

   initial begin
      int n, p, s1, r1, g0, gl, gr, s2, r2, len, k;
      bit quiet;
      logic [8:0] g;
      logic [7:0] b;
      logic [3:0] nb[$];

      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      last  = 1'b0;
      v4 = 1'b0;
      d4 = '0;
      l4 = 1'b0;

      // frame A5,3C,01 streamed with valid held high
      add(1,1,8'hA5,0, 0,4'h0,0,0,1,0);
      add(1,1,8'h3C,0, 1,4'h5,0,0,0,1);
      add(1,1,8'h3C,0, 1,4'hA,0,0,1,1);
      add(1,1,8'h01,1, 1,4'hC,0,0,0,1);
      add(1,1,8'h01,1, 1,4'h3,0,0,1,1);
      add(1,0,8'h00,0, 1,4'h1,0,0,0,1);
      add(1,0,8'h00,0, 1,4'h0,0,0,0,1);
      // underrun then drain of 22,33
      add(1,1,8'h11,0, 0,4'h0,0,0,1,0);
      add(1,0,8'h00,0, 1,4'h1,0,0,0,1);
      add(1,0,8'h00,0, 1,4'h1,0,0,1,1);
      add(1,0,8'h00,0, 1,4'h0,1,1,0,1);
      add(1,1,8'h22,0, 0,4'h0,0,0,1,1);
      add(1,1,8'h33,1, 0,4'h0,0,0,1,1);
      add(1,0,8'h00,0, 0,4'h0,0,0,0,1);
      // reset during HI of byte 2, restart with no gap
      add(1,1,8'h12,0, 0,4'h0,0,0,1,0);
      add(1,1,8'h34,0, 1,4'h2,0,0,0,1);
      add(1,1,8'h34,0, 1,4'h1,0,0,1,1);
      add(1,1,8'h56,0, 1,4'h4,0,0,0,1);
      add(0,1,8'h56,0, 1,4'h3,0,0,0,1);
      add(0,1,8'h56,0, 0,4'h0,0,0,0,0);
      add(1,1,8'h56,0, 0,4'h0,0,0,1,0);
      add(1,1,8'h78,1, 1,4'h6,0,0,0,1);
      add(1,1,8'h78,1, 1,4'h5,0,0,1,1);
      add(1,0,8'h00,0, 1,4'h8,0,0,0,1);
      add(1,0,8'h00,0, 1,4'h7,0,0,0,1);
      add(1,0,8'h00,0, 0,4'h0,0,0,0,1);

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      g = {en, txd, er, und, rdy, busy};
      chk("reset_outputs", int'(g), 0);
      g = {en4, txd4, er4, und4, rdy4, busy4};
      chk("reset_outputs4", int'(g), 0);
      @(posedge clk);
      #1;

      apply_rows(0, 6);
      valid = 1'b0;
      n = 0;
      quiet = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (en) quiet = 0;
         if (rdy) break;
         n++;
         @(posedge clk);
         #1;
      end
      chk("t1_txen_low_gap", n + 1, IPG);
      chk("t1_txen_quiet", int'(quiet && !en), 1);
      @(posedge clk);
      #1;

      apply_rows(7, 13);
      wait_idle("underrun_idle");
      apply_rows(14, 25);
      wait_idle("reset_idle");

      // single-byte frame
      send(8'h7E, 1'b1);
      valid = 1'b0;
      nb.delete();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (en) nb.push_back(txd);
         @(posedge clk);
         #1;
      end
      chk("single_busy_cycles", n, IPG + 1);
      chk("single_nibbles",
          (nb.size() == 2) ? int'({nb[0], nb[1]}) : -1, 'hE7);
      @(posedge clk);
      #1;

      // IPG_NIBBLES=4 instance: back-to-back frames
      fork
         begin
            send4(8'h21, 1'b0);
            send4(8'h43, 1'b1);
            send4(8'h65, 1'b1);
            v4 = 1'b0;
         end
         begin
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               rec_en[i]  = en4;
               rec_rdy[i] = rdy4;
               rec_txd[i] = txd4;
            end
         end
      join
      p = 0;
      while (p < 40 && !rec_en[p]) p++;
      s1 = p;
      while (p < 40 && rec_en[p]) p++;
      r1 = p - s1;
      g0 = p;
      gr = 0;
      while (p < 40 && !rec_en[p]) begin
         gr += int'(rec_rdy[p]);
         p++;
      end
      gl = p - g0;
      s2 = p;
      while (p < 40 && rec_en[p]) p++;
      r2 = p - s2;
      chk("ipg4_frame1_len", r1, 4);
      chk("ipg4_gap", gl, IPG4);
      chk("ipg4_ready_in_gap", gr, 1);
      chk("ipg4_frame2_len", r2, 2);
      chk("ipg4_frame1_nib", (s1 + 3 < 40) ?
          int'({rec_txd[s1], rec_txd[s1+1],
                rec_txd[s1+2], rec_txd[s1+3]}) : -1, 'h1234);
      chk("ipg4_frame2_nib", (s2 + 1 < 40) ?
          int'({rec_txd[s2], rec_txd[s2+1]}) : -1, 'h56);

      // random frames against the frame-level model
      @(posedge clk);
      #1;
      mon_en = 1;
      for (int f = 0; f < NF; f++) begin
         len = int'($urandom_range(1, 8));
         k = ($urandom_range(0, 1) == 0) ? 0 :
             int'($urandom_range(1, 32));
         if (f == 0) k = 0;
         valid = 1'b0;
         repeat (k) begin
            @(posedge clk);
            #1;
         end
         exp_gap.push_back((f == 0) ? -1 : k);
         exp_len.push_back(2 * len);
         for (int j = 0; j < len; j++) begin
            b = 8'($urandom);
            exp_nib.push_back(b[3:0]);
            exp_nib.push_back(b[7:4]);
            send(b, (j == len - 1));
         end
      end
      wait_idle("rnd_idle");
      repeat (2) @(posedge clk);
      #1;
      mon_en = 0;
      chk("rnd_frames_left", exp_len.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
